sccb_slave: RTL and testbench

- SCCB/I2C-style responder that models the camera end of the camera control bus.
- Decodes 3-phase writes (ID, addr-hi, addr-lo, data) and 2-phase-write-plus-read sequences (ID, addr-hi, addr-lo, stop, ID|1, data).
- Translates decoded transfers into a simple register-port handshake toward a register file or camera model.
- Used in simulation and in loopback test builds against the SCCB master.

---
 rtl/sccb_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sccb_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB camera-side responder with register port; define SCCB_AUTOINC_EN for address auto-increment
module sccb_slave #(
    parameter logic [6:0] DEV_ID      = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        id_miss
);
    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, ADDR_H, AH_ACK, ADDR_L, AL_ACK,
        WDATA, WD_ACK, RDATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   start_det;
    logic                   stop_det;
    logic                   scl_rise;
    logic                   scl_fall;
    logic [7:0]             byte_in;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_cnt_nxt;
    logic [7:0]  shift;
    logic [7:0]  shift_nxt;
    logic        sda_oe_nxt;
    logic [15:0] addr_nxt;
    logic [7:0]  wdata_nxt;
    logic        we_nxt;
    logic        re_nxt;
    logic        busy_nxt;
    logic        id_miss_nxt;
    logic        load_pend;     // reg_rdata is valid this clk; load it and drive the MSB
    logic        load_nxt;
    logic        ack_rise;      // master ACK seen on the 9th rise of a read byte
    logic        ack_rise_nxt;
    logic        more;          // a write byte already landed in this transfer
    logic        more_nxt;

    // Synchronize bus lines; idle-high reset values keep reset release from looking like START
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign byte_in   = {shift[6:0], sda_s};

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            sda_oe    <= 1'b0;
            reg_addr  <= 16'h0000;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            id_miss   <= 1'b0;
            load_pend <= 1'b0;
            ack_rise  <= 1'b0;
            more      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            sda_oe    <= sda_oe_nxt;
            reg_addr  <= addr_nxt;
            reg_wdata <= wdata_nxt;
            reg_we    <= we_nxt;
            reg_re    <= re_nxt;
            busy      <= busy_nxt;
            id_miss   <= id_miss_nxt;
            load_pend <= load_nxt;
            ack_rise  <= ack_rise_nxt;
            more      <= more_nxt;
        end
    end

    // Next-state decode; ACK states toggle sda_oe on each SCL fall (first fall pulls, second releases)
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        sda_oe_nxt   = sda_oe;
        addr_nxt     = reg_addr;
        wdata_nxt    = reg_wdata;
        we_nxt       = 1'b0;
        re_nxt       = 1'b0;
        busy_nxt     = busy;
        id_miss_nxt  = 1'b0;
        load_nxt     = 1'b0;
        ack_rise_nxt = ack_rise;
        more_nxt     = more;

        if (start_det) begin
            state_nxt    = ID;
            bit_cnt_nxt  = 3'd0;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b1;
            ack_rise_nxt = 1'b0;
            more_nxt     = 1'b0;
        end else if (stop_det) begin
            state_nxt    = IDLE;
            bit_cnt_nxt  = 3'd0;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b0;
            ack_rise_nxt = 1'b0;
            more_nxt     = 1'b0;
        end else if (load_pend) begin
            shift_nxt  = reg_rdata;
            sda_oe_nxt = ~reg_rdata[7];
        end else begin
            case (state)
                IDLE: ;
                ID: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == DEV_ID) begin
                                state_nxt = ID_ACK;
                            end else begin
                                id_miss_nxt = 1'b1;
                                state_nxt   = WAIT_STOP;
                            end
                        end
                    end
                end
                ID_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = ~sda_oe;
                        if (sda_oe) begin
                            if (shift[0]) begin
                                re_nxt    = 1'b1;
                                load_nxt  = 1'b1;
                                state_nxt = RDATA;
                            end else begin
                                state_nxt = ADDR_H;
                            end
                        end
                    end
                end
                ADDR_H: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr_nxt[15:8] = byte_in;
                            state_nxt      = AH_ACK;
                        end
                    end
                end
                AH_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = ~sda_oe;
                        if (sda_oe) state_nxt = ADDR_L;
                    end
                end
                ADDR_L: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr_nxt[7:0] = byte_in;
                            state_nxt     = AL_ACK;
                        end
                    end
                end
                AL_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = ~sda_oe;
                        if (sda_oe) begin
                            more_nxt  = 1'b0;
                            state_nxt = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wdata_nxt = byte_in;
                            we_nxt    = 1'b1;
                            if (more) addr_nxt = reg_addr + 16'd1;
                            state_nxt = WD_ACK;
                        end
                    end
                end
                WD_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = ~sda_oe;
                        if (sda_oe) begin
`ifdef SCCB_AUTOINC_EN
                            more_nxt  = 1'b1;
                            state_nxt = WDATA;
`else
                            state_nxt = WAIT_STOP;
`endif
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_rise_nxt = 1'b0;
                            state_nxt    = RD_ACK;
                        end
                    end else if (scl_fall && bit_cnt != 3'd0) begin
                        shift_nxt  = {shift[6:0], 1'b0};
                        sda_oe_nxt = ~shift[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_nxt = WAIT_STOP;
                        else       ack_rise_nxt = 1'b1;
                    end else if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        if (ack_rise) begin
                            ack_rise_nxt = 1'b0;
                            re_nxt       = 1'b1;
                            load_nxt     = 1'b1;
`ifdef SCCB_AUTOINC_EN
                            addr_nxt     = reg_addr + 16'd1;
`endif
                            state_nxt    = RDATA;
                        end
                    end
                end
                WAIT_STOP: ;
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - directed bench for sccb_slave acting as bus master with open-drain SDA
module tb_sccb_slave;
    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [7:0]  reg_rdata = 8'h00;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic        busy;
    logic        id_miss;
    logic        sda_bus;

    assign sda_bus = m_sda & ~sda_oe;

    sccb_slave #(.DEV_ID(7'h3C), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .id_miss(id_miss)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int miss_cnt = 0;
    logic [15:0] wr_addr [8];
    logic [7:0]  wr_data [8];
    logic [15:0] rd_addr [8];

    always @(negedge clk) begin
        if (reg_we) begin
            wr_addr[we_cnt % 8] <= reg_addr;
            wr_data[we_cnt % 8] <= reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (reg_re) begin
            rd_addr[re_cnt % 8] <= reg_addr;
            re_cnt <= re_cnt + 1;
        end
        if (id_miss) miss_cnt <= miss_cnt + 1;
    end

    task automatic bus_start();
        m_sda = 1'b1; #(Q);
        m_scl = 1'b1; #(Q);
        m_sda = 1'b0; #(Q);
        m_scl = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #(Q);
        m_scl = 1'b1; #(Q);
        m_sda = 1'b1; #(Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        if (glitch) begin
            m_sda = ~b; #20; m_sda = b; #20; m_sda = ~b; #20; m_sda = b; #(Q-60);
        end else begin
            m_sda = b; #(Q);
        end
        m_scl = 1'b1; #(2*Q);
        m_scl = 1'b0; #(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; #(Q);
        m_scl = 1'b1; #(Q);
        b = sda_bus;  #(Q);
        m_scl = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #22;
        n_vec++; if (sda_oe !== 1'b0)       begin n_err++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_vec++; if (reg_addr !== 16'h0000) begin n_err++; $display("FAIL reset_reg_addr: got %h expected 0000", reg_addr); end
        n_vec++; if (reg_wdata !== 8'h00)   begin n_err++; $display("FAIL reset_reg_wdata: got %h expected 00", reg_wdata); end
        n_vec++; if (reg_we !== 1'b0)       begin n_err++; $display("FAIL reset_reg_we: got %b expected 0", reg_we); end
        n_vec++; if (reg_re !== 1'b0)       begin n_err++; $display("FAIL reset_reg_re: got %b expected 0", reg_re); end
        n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (id_miss !== 1'b0)      begin n_err++; $display("FAIL reset_id_miss: got %b expected 0", id_miss); end
        rst = 1'b0;
        #(Q);
    endtask

    task automatic test_write();
        logic [7:0] bytes [4] = '{8'h78, 8'h30, 8'h0A, 8'h00};
        logic ack;
        int base = we_cnt;
        bus_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy_on: got %b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], 1'b0, ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL write_ack%0d: got %b expected 0", i, ack); end
        end
        bus_stop();
        #(Q);
        n_vec++; if (we_cnt - base !== 1) begin n_err++; $display("FAIL write_we_count: got %0d expected 1", we_cnt - base); end
        n_vec++; if (wr_addr[base % 8] !== 16'h300A) begin n_err++; $display("FAIL write_addr: got %h expected 300A", wr_addr[base % 8]); end
        n_vec++; if (wr_data[base % 8] !== 8'h00) begin n_err++; $display("FAIL write_data: got %h expected 00", wr_data[base % 8]); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_off: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        logic [7:0] bytes [3] = '{8'h78, 8'h30, 8'h0A};
        logic [7:0] d;
        logic ack;
        int base = re_cnt;
        int wbase = we_cnt;
        reg_rdata = 8'h56;
        bus_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(bytes[i], 1'b0, ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_setup_ack%0d: got %b expected 0", i, ack); end
        end
        bus_stop();
        bus_start();
        write_byte(8'h79, 1'b0, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_id_ack: got %b expected 0", ack); end
        read_byte(1'b1, d);
        bus_stop();
        #(Q);
        n_vec++; if (d !== 8'h56) begin n_err++; $display("FAIL read_data: got %h expected 56", d); end
        n_vec++; if (re_cnt - base !== 1) begin n_err++; $display("FAIL read_re_count: got %0d expected 1", re_cnt - base); end
        n_vec++; if (rd_addr[base % 8] !== 16'h300A) begin n_err++; $display("FAIL read_addr: got %h expected 300A", rd_addr[base % 8]); end
        n_vec++; if (we_cnt - wbase !== 0) begin n_err++; $display("FAIL read_no_we: got %0d expected 0", we_cnt - wbase); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_busy_off: got %b expected 0", busy); end
    endtask

    task automatic test_id_miss();
        logic ack;
        int wbase = we_cnt;
        int rbase = re_cnt;
        int mbase = miss_cnt;
        bus_start();
        write_byte(8'h42, 1'b0, ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL miss_id_ack: got %b expected 1", ack); end
        write_byte(8'h11, 1'b0, ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL miss_next_ack: got %b expected 1", ack); end
        bus_stop();
        #(Q);
        n_vec++; if (miss_cnt - mbase !== 1) begin n_err++; $display("FAIL miss_pulse_count: got %0d expected 1", miss_cnt - mbase); end
        n_vec++; if (we_cnt - wbase !== 0) begin n_err++; $display("FAIL miss_no_we: got %0d expected 0", we_cnt - wbase); end
        n_vec++; if (re_cnt - rbase !== 0) begin n_err++; $display("FAIL miss_no_re: got %0d expected 0", re_cnt - rbase); end
    endtask

    task automatic test_abort();
        logic [7:0] bytes [3] = '{8'h78, 8'h12, 8'h34};
        logic [7:0] again [4] = '{8'h78, 8'h55, 8'h66, 8'h77};
        logic [3:0] nib = 4'b1011;
        logic ack;
        int base = we_cnt;
        bus_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(bytes[i], 1'b0, ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL abort_ack%0d: got %b expected 0", i, ack); end
        end
        for (int i = 3; i >= 0; i--) send_bit(nib[i], 1'b0);
        bus_stop();
        #(Q);
        n_vec++; if (we_cnt - base !== 0) begin n_err++; $display("FAIL abort_no_we: got %0d expected 0", we_cnt - base); end
        n_vec++; if (reg_addr !== 16'h1234) begin n_err++; $display("FAIL abort_addr: got %h expected 1234", reg_addr); end
        base = we_cnt;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(again[i], 1'b0, ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL abort_next_ack%0d: got %b expected 0", i, ack); end
        end
        bus_stop();
        #(Q);
        n_vec++; if (we_cnt - base !== 1) begin n_err++; $display("FAIL abort_next_we: got %0d expected 1", we_cnt - base); end
        n_vec++; if (wr_addr[base % 8] !== 16'h5566) begin n_err++; $display("FAIL abort_next_addr: got %h expected 5566", wr_addr[base % 8]); end
        n_vec++; if (wr_data[base % 8] !== 8'h77) begin n_err++; $display("FAIL abort_next_data: got %h expected 77", wr_data[base % 8]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] lo = 8'h56;
        logic ack;
        bus_start();
        write_byte(8'h78, 1'b0, ack);
        write_byte(8'h12, 1'b0, ack);
        for (int i = 7; i >= 0; i--) send_bit(lo[i], 1'b0);
        n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rstmid_ack_drive: got %b expected 1", sda_oe); end
        n_vec++; if (reg_addr !== 16'h1256) begin n_err++; $display("FAIL rstmid_addr_before: got %h expected 1256", reg_addr); end
        #3;
        rst = 1'b1;
        #1;
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_sda_oe: got %b expected 0", sda_oe); end
        n_vec++; if (reg_addr !== 16'h0000) begin n_err++; $display("FAIL rstmid_addr: got %h expected 0000", reg_addr); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        m_sda = 1'b1;
        m_scl = 1'b1;
        #50;
        rst = 1'b0;
        #(Q);
    endtask

    task automatic test_autoinc();
        logic [7:0] bytes [5] = '{8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB};
        logic ack;
        int base = we_cnt;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], 1'b0, ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL inc_ack%0d: got %b expected 0", i, ack); end
        end
        write_byte(bytes[4], 1'b0, ack);
        bus_stop();
        #(Q);
        n_vec++; if (wr_addr[base % 8] !== 16'hFFFF) begin n_err++; $display("FAIL inc_addr0: got %h expected FFFF", wr_addr[base % 8]); end
        n_vec++; if (wr_data[base % 8] !== 8'hAA) begin n_err++; $display("FAIL inc_data0: got %h expected AA", wr_data[base % 8]); end
`ifdef SCCB_AUTOINC_EN
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL inc_ack4: got %b expected 0", ack); end
        n_vec++; if (we_cnt - base !== 2) begin n_err++; $display("FAIL inc_we_count: got %0d expected 2", we_cnt - base); end
        n_vec++; if (wr_addr[(base + 1) % 8] !== 16'h0000) begin n_err++; $display("FAIL inc_addr1: got %h expected 0000", wr_addr[(base + 1) % 8]); end
        n_vec++; if (wr_data[(base + 1) % 8] !== 8'hBB) begin n_err++; $display("FAIL inc_data1: got %h expected BB", wr_data[(base + 1) % 8]); end
`else
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL inc_extra_nack: got %b expected 1", ack); end
        n_vec++; if (we_cnt - base !== 1) begin n_err++; $display("FAIL inc_we_count: got %0d expected 1", we_cnt - base); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h78, 8'h00, 8'h10};
        logic [7:0] d;
        logic ack;
        int base = re_cnt;
        reg_rdata = 8'hA5;
        bus_start();
        for (int i = 0; i < 3; i++) write_byte(bytes[i], 1'b0, ack);
        bus_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        write_byte(8'h79, 1'b0, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL b2b_id_ack: got %b expected 0", ack); end
        read_byte(1'b1, d);
        bus_stop();
        #(Q);
        n_vec++; if (d !== 8'hA5) begin n_err++; $display("FAIL b2b_data: got %h expected A5", d); end
        n_vec++; if (re_cnt - base !== 1) begin n_err++; $display("FAIL b2b_re_count: got %0d expected 1", re_cnt - base); end
        n_vec++; if (rd_addr[base % 8] !== 16'h0010) begin n_err++; $display("FAIL b2b_addr: got %h expected 0010", rd_addr[base % 8]); end
    endtask

    task automatic test_glitch();
        logic [7:0] bytes [4] = '{8'h78, 8'h20, 8'h21, 8'h5A};
        logic ack;
        int base = we_cnt;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], 1'b1, ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL glitch_ack%0d: got %b expected 0", i, ack); end
        end
        bus_stop();
        #(Q);
        n_vec++; if (we_cnt - base !== 1) begin n_err++; $display("FAIL glitch_we_count: got %0d expected 1", we_cnt - base); end
        n_vec++; if (wr_addr[base % 8] !== 16'h2021) begin n_err++; $display("FAIL glitch_addr: got %h expected 2021", wr_addr[base % 8]); end
        n_vec++; if (wr_data[base % 8] !== 8'h5A) begin n_err++; $display("FAIL glitch_data: got %h expected 5A", wr_data[base % 8]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_id_miss();
        test_abort();
        test_reset_mid();
        test_autoinc();
        test_back_to_back();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
